// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and a 512x8 byte-addressed RAM.
// Validates each request, runs the RAM handshake and extends load data to 32 bits.
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              memFuncActive,
  output logic              readWrite,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        dataSize,
  output logic [31:0]       dataIn,
  input  logic [31:0]       dataOut,
  input  logic              memFuncComplete
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FAIL} state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t            state_q;
  logic              sgn_q;
  logic [3:0]        cnt_q;
  logic              busy_q, done_q, err_q, mfa_q, rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        dsize_q;
  logic [31:0]       din_q, rdata_q;
  logic              illegal_d;
  logic [31:0]       din_d;

  function automatic logic [31:0] place_store(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {24'h0, w[7:0]};
      2'b01:   return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Upper lanes of dataOut are stale for narrow loads and must never leak into rdata.
  function automatic logic [31:0] extend_load(input logic [1:0] sz, input logic s,
                                              input logic [31:0] d);
    case (sz)
      2'b00:   return {{24{s & d[7]}}, d[7:0]};
      2'b01:   return {{16{s & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    illegal_d = (size == 2'b10) ||
                ((size == 2'b01) && addr[0]) ||
                ((size == 2'b11) && (addr[1:0] != 2'b00));
    din_d     = place_store(size, wdata);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mfa_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      dsize_q <= 2'b00;
      din_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            sgn_q  <= sgn;
            if (illegal_d) begin
              err_q   <= 1'b1;
              state_q <= S_FAIL;
            end else begin
              addr_q  <= addr;
              dsize_q <= size;
              rw_q    <= we;
              if (we) din_q <= din_d;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          mfa_q   <= 1'b1;
          cnt_q   <= 4'd0;
          state_q <= S_WAIT;
        end
        // memFuncComplete is only trusted here; a leftover 1 seen during ISSUE is stale.
        S_WAIT: begin
          if (memFuncComplete) begin
            if (!rw_q) rdata_q <= extend_load(dsize_q, sgn_q, dataOut);
            mfa_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            mfa_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_FAIL;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAIL: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign memFuncActive = mfa_q;
  assign readWrite     = rw_q;
  assign address       = addr_q;
  assign dataSize      = dsize_q;
  assign dataIn        = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a big-endian RAM model with variable latency,
// and a transaction-level reference memory that predicts outcome, latency and rdata.
module tb_mem_access_ctrl;

  logic        Clk, Reset_n;
  logic        req, we, sgn;
  logic [1:0]  size;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        memFuncActive, readWrite;
  logic [8:0]  address;
  logic [1:0]  dataSize;
  logic [31:0] dataIn, dataOut;
  logic        memFuncComplete;

  mem_access_ctrl #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .we(we), .size(size), .sgn(sgn),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .memFuncActive(memFuncActive), .readWrite(readWrite), .address(address),
    .dataSize(dataSize), .dataIn(dataIn), .dataOut(dataOut),
    .memFuncComplete(memFuncComplete)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM model: completes ram_lat cycles after seeing activation; completion flag is
  // left high afterwards (stale) and masked combinationally on the activation cycle.
  logic [7:0]  ram_mem [512];
  logic [31:0] dout_r, last_din;
  logic        ram_done, act_prev, tie_low;
  int          ram_lat, wcnt;

  assign dataOut         = dout_r;
  assign memFuncComplete = ram_done & ~(memFuncActive & ~act_prev) & ~tie_low;

  always @(posedge Clk or negedge Reset_n) begin : ram_blk
    logic        act_now;
    int          a;
    logic [31:0] r;
    if (!Reset_n) begin
      ram_done <= 1'b0;
      act_prev <= 1'b0;
      wcnt     <= 0;
    end else begin
      act_now  = 1'b0;
      a        = int'(address);
      r        = $urandom;
      act_prev <= memFuncActive;
      if (memFuncActive && !act_prev) begin
        wcnt     <= 0;
        ram_done <= 1'b0;
        act_now  = (ram_lat == 0) && !tie_low;
      end else if (memFuncActive && !ram_done && !tie_low) begin
        wcnt    <= wcnt + 1;
        act_now = (wcnt + 1 == ram_lat);
      end
      if (act_now) begin
        ram_done <= 1'b1;
        if (readWrite) begin
          last_din <= dataIn;
          case (dataSize)
            2'b00: ram_mem[a] <= dataIn[7:0];
            2'b01: begin ram_mem[a] <= dataIn[15:8]; ram_mem[a+1] <= dataIn[7:0]; end
            default: begin
              ram_mem[a]   <= dataIn[31:24]; ram_mem[a+1] <= dataIn[23:16];
              ram_mem[a+2] <= dataIn[15:8];  ram_mem[a+3] <= dataIn[7:0];
            end
          endcase
        end else begin
          case (dataSize)
            2'b00:   dout_r <= {r[31:8], ram_mem[a]};
            2'b01:   dout_r <= {r[31:16], ram_mem[a], ram_mem[a+1]};
            default: dout_r <= {ram_mem[a], ram_mem[a+1], ram_mem[a+2], ram_mem[a+3]};
          endcase
        end
      end
    end
  end

  // Reference model: plain byte array, big-endian, loads computed arithmetically.
  logic [7:0]  ref_mem [512];
  logic [31:0] ref_rdata;

  function automatic int nbytes_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic s);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < nbytes_of(sz); i++) v = v * 256 + 32'(ref_mem[a+i]);
    if (sz == 2'b00 && s && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (sz == 2'b01 && s && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic run_req(input logic t_we, input logic [1:0] t_size, input logic t_sgn,
                         input logic [8:0] t_addr, input logic [31:0] t_wdata,
                         input int t_lat, input logic t_tie);
    int          nb, k, exp_k, a;
    logic        illegal, exp_err, mfa_seen;
    logic [31:0] w;
    nb      = nbytes_of(t_size);
    a       = int'(t_addr);
    illegal = (nb == 0) || ((a % nb) != 0);
    exp_err = illegal || t_tie;
    exp_k   = illegal ? 0 : (t_tie ? 16 : 3 + t_lat);
    @(negedge Clk);
    ram_lat = t_lat; tie_low = t_tie;
    req = 1'b1; we = t_we; size = t_size; sgn = t_sgn; addr = t_addr; wdata = t_wdata;
    @(posedge Clk); #1;
    req = 1'b0;
    check_eq("busy_accept", busy, 1);
    k = 0; mfa_seen = 0;
    while (!(done || err) && k < 40) begin
      if (memFuncActive) mfa_seen = 1;
      req = 1'($urandom % 2); we = 1'($urandom % 2); size = 2'($urandom % 4);
      addr = 9'($urandom); wdata = $urandom; sgn = 1'($urandom % 2);
      @(posedge Clk); #1;
      k++;
    end
    req = 1'b0;
    check_eq("latency", k, exp_k);
    check_eq("done", done, !exp_err);
    check_eq("err", err, exp_err);
    check_eq("mfa_issued", mfa_seen, !illegal);
    check_eq("mfa_at_pulse", memFuncActive, 0);
    if (!exp_err) begin
      if (t_we) begin
        w = (nb == 1) ? t_wdata % 256 : (nb == 2) ? t_wdata % 65536 : t_wdata;
        check_eq("dataIn_lane", last_din, w);
        for (int i = 0; i < nb; i++) ref_mem[a+i] = 8'(w >> (8 * (nb - 1 - i)));
        for (int i = 0; i < nb; i++) check_eq("ram_byte", ram_mem[a+i], ref_mem[a+i]);
      end else begin
        ref_rdata = ref_load(a, t_size, t_sgn);
      end
    end
    check_eq("rdata", rdata, ref_rdata);
    @(posedge Clk); #1;
    check_eq("exit_idle", {busy, done, err}, 0);
  endtask

  initial begin
    Reset_n = 1'b0; req = 0; we = 0; sgn = 0; size = 0; addr = 0; wdata = 0;
    ram_lat = 0; tie_low = 0; ref_rdata = 0; dout_r = 0; last_din = 0;
    for (int i = 0; i < 512; i++) begin ram_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    ram_mem[2] = 8'h08; ram_mem[3] = 8'h21; ref_mem[2] = 8'h08; ref_mem[3] = 8'h21;

    repeat (2) @(posedge Clk); #1;
    check_eq("rst_ctrl", {busy, done, err, memFuncActive, readWrite}, 0);
    check_eq("rst_address", address, 0);
    check_eq("rst_dataSize", dataSize, 0);
    check_eq("rst_dataIn", dataIn, 0);
    check_eq("rst_rdata", rdata, 0);
    @(negedge Clk); Reset_n = 1'b1;

    run_req(1, 2'b11, 0, 9'h010, 32'hDEADBEEF, 0, 0);
    check_eq("tp_ram_word", {ram_mem[16], ram_mem[17], ram_mem[18], ram_mem[19]}, 32'hDEADBEEF);
    run_req(0, 2'b11, 0, 9'h010, 32'h0, 0, 0);
    check_eq("tp_load_word", rdata, 32'hDEADBEEF);
    run_req(1, 2'b00, 0, 9'h021, 32'h12345680, 1, 0);
    run_req(0, 2'b00, 1, 9'h021, 32'h0, 2, 0);
    check_eq("tp_byte_sx", rdata, 32'hFFFFFF80);
    run_req(0, 2'b00, 0, 9'h021, 32'h0, 0, 0);
    check_eq("tp_byte_zx", rdata, 32'h00000080);
    run_req(1, 2'b01, 0, 9'h030, 32'hAAAA8001, 0, 0);
    run_req(0, 2'b01, 1, 9'h030, 32'h0, 3, 0);
    check_eq("tp_half_sx", rdata, 32'hFFFF8001);
    run_req(0, 2'b01, 0, 9'h030, 32'h0, 0, 0);
    check_eq("tp_half_zx", rdata, 32'h00008001);
    run_req(0, 2'b01, 1, 9'h031, 32'h0, 0, 0);
    run_req(0, 2'b11, 0, 9'h102, 32'h0, 0, 0);
    run_req(1, 2'b10, 0, 9'h040, 32'hFFFFFFFF, 0, 0);
    check_eq("tp_illegal_rdata", rdata, 32'h00008001);
    run_req(0, 2'b11, 1, 9'h010, 32'h0, 0, 1);
    run_req(1, 2'b11, 0, 9'h1FC, 32'hCAFEF00D, 0, 0);
    run_req(0, 2'b11, 0, 9'h1FC, 32'h0, 1, 0);
    run_req(0, 2'b00, 1, 9'h1FF, 32'h0, 0, 0);
    check_eq("tp_last_byte", rdata, 32'h0000000D);

    // Abort a load while the controller sits in WAIT.
    @(negedge Clk);
    ram_lat = 3; tie_low = 0; req = 1; we = 0; size = 2'b11; sgn = 0; addr = 9'h000;
    @(posedge Clk); #1; req = 0;
    @(posedge Clk); #1;
    check_eq("pre_rst_mfa", memFuncActive, 1);
    @(posedge Clk); #3;
    Reset_n = 1'b0; #1;
    check_eq("async_rst_mfa", memFuncActive, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_rdata", rdata, 0);
    ref_rdata = 0;
    @(negedge Clk); Reset_n = 1'b1;
    run_req(0, 2'b11, 0, 9'h000, 32'h0, 0, 0);
    check_eq("post_rst_load", rdata, 32'h00000821);

    for (int i = 0; i < 80; i++) begin : rnd
      logic [1:0] s;
      logic [8:0] a;
      s = 2'($urandom % 4);
      a = 9'(4 + $urandom % 508);
      if ($urandom % 4 != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b11) a[1:0] = 2'b00;
      end
      run_req(1'($urandom % 2), s, 1'($urandom % 2), a, $urandom,
              int'($urandom % 4), ($urandom % 12) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the CPU datapath and the 512x8 byte-addressed RAM.
- Accepts one request at a time and validates size and alignment.
- Drives the RAM's memFuncActive/readWrite/address/dataSize/dataIn handshake and waits for memFuncComplete.
- Returns load data zero- or sign-extended to 32 bits, and flags illegal or timed-out accesses.

Parameters:
- ADDR_W, 9, RAM address width (512 bytes).
- TIMEOUT, 15, max cycles in WAIT before error; counter is 4 bits wide.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe, sampled in IDLE only.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 11 word; 10 illegal.
- sgn  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  in  9  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- busy  out  1  high from request accept until done/err pulse.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on illegal size, misalignment or timeout.
- rdata  out  32  extended load result; held until next accepted load.
- memFuncActive  out  1  to RAM.
- readWrite  out  1  to RAM: 1 write, 0 read.
- address  out  9  to RAM.
- dataSize  out  2  to RAM.
- dataIn  out  32  to RAM.
- dataOut  in  32  from RAM.
- memFuncComplete  in  1  from RAM.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; busy, done, err, memFuncActive, readWrite = 0; address=0; dataSize=0; dataIn=0; rdata=0; timeout counter=0.
- A reset mid-access drops memFuncActive immediately and discards the request.
- IDLE: if req=1, latch we/size/sgn/addr/wdata and set busy=1.
  - If size=10, or (size=01 and addr[0]=1), or (size=11 and addr[1:0]!=0), go to FAIL.
  - Otherwise go to ISSUE.
  - req while busy is ignored (no queuing).
- ISSUE, 1 cycle: drive address, dataSize, readWrite=we.
  - For stores, drive dataIn with wdata placed at the RAM lane: word → [31:0], halfword → [15:0], byte → [7:0]. Other bits are 0.
  - memFuncActive rises at the end of ISSUE; go to WAIT and clear the counter.
- WAIT: memFuncActive=1 and the RAM outputs are held stable.
  - memFuncComplete is sampled only from the first WAIT edge onward. The RAM resets it combinationally on activation, so a stale 1 left from a previous access must never be taken during ISSUE.
  - On complete=1: capture and extend the load result, then go to DONE.
  - Otherwise increment the counter. On count==TIMEOUT go to FAIL.
- Load result extension, with fill bit f = sgn & MSB of the field (f=0 when sgn=0):
  - Word: rdata = dataOut, no extension.
  - Halfword: rdata = {16{f}}, dataOut[15:0]. Bits dataOut[31:16] are stale from the RAM and must be ignored.
  - Byte: rdata = {24{f}}, dataOut[7:0]. Bits dataOut[31:8] must be ignored.
- Stores leave rdata unchanged.
- DONE, 1 cycle: memFuncActive=0, done=1, busy=0 on exit; go to IDLE.
- FAIL, 1 cycle: memFuncActive=0, err=1, rdata unchanged, no RAM access issued for illegal or misaligned requests; go to IDLE.
- Latency:
  - Legal access: req accepted at edge N, memFuncActive high from N+1, done at N+3 with a zero-wait RAM.
  - Next req is accepted in the cycle after done/err.
- Address wrap-around: a word at 508 is legal; the last byte index is 511, with no wrap.
- done and err are never high together. busy is never high in IDLE.

Test Plan:
- Store word wdata=32'hDEADBEEF at addr 0x010, then load word from 0x010 → done pulse 3 cycles after req, rdata=32'hDEADBEEF, RAM bytes at 0x010–0x013 = DE AD BE EF.
- Store byte 8'h80 at 0x021, then load byte sgn=1 → rdata=32'hFFFFFF80; same load with sgn=0 → 32'h00000080; dataOut[31:8] garbage has no effect.
- Store halfword 16'h8001 at 0x030, then load halfword sgn=1 → rdata=32'hFFFF8001; sgn=0 → 32'h00008001.
- Load halfword at 0x031, load word at 0x102, and a request with size=10 → err pulse 1 cycle after req, memFuncActive never asserted, rdata unchanged.
- Model with memFuncComplete tied low → err pulse after TIMEOUT=15 WAIT cycles, memFuncActive drops with err.
- Reset_n pulled low during WAIT → memFuncActive=0 and busy=0 asynchronously; after release, a new load of 0x000 returns 32'h00000821.
